// File: rtl/unidade_controle_jogo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | unidade_controle_jogo: Moore control FSM sequencing the memory-game      |
// | datapath (clear, wait play, latch, compare, advance, timeout).           |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module unidade_controle_jogo #(
    parameter int TIMEOUT = 5000,
    parameter int TW      = 13
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic       jogada_feita,
    input  logic       igual,
    input  logic       fimC,
    output logic       zeraC,
    output logic       contaC,
    output logic       zeraR,
    output logic       registraR,
    output logic       pronto,
    output logic       acertou,
    output logic       errou,
    output logic       timeout,
    output logic [3:0] db_estado
);

    typedef enum logic [3:0] {
        INICIAL     = 4'b0000,
        PREPARACAO  = 4'b0001,
        ESPERA      = 4'b0010,
        REGISTRA    = 4'b0100,
        COMPARACAO  = 4'b0101,
        PROXIMO     = 4'b0110,
        FIM_ACERTO  = 4'b1010,
        FIM_ERRO    = 4'b1110,
        FIM_TIMEOUT = 4'b1101
    } estado_t;

    localparam logic [TW-1:0] TIMER_MAX = TW'(TIMEOUT - 1);

    estado_t       estado;
    estado_t       prox_estado;
    logic [TW-1:0] timer;
    logic          timer_fim;

    assign timer_fim = (timer == TIMER_MAX);
    assign db_estado = estado;

    always_ff @(posedge clock) begin
        if (!reset) begin
            estado <= INICIAL;
        end else begin
            estado <= prox_estado;
        end
    end

    // Saturates at TIMEOUT-1 so a held espera can never wrap back to zero.
    always_ff @(posedge clock) begin
        if (!reset) begin
            timer <= '0;
        end else if (estado != ESPERA) begin
            timer <= '0;
        end else if (!timer_fim) begin
            timer <= timer + 1'b1;
        end
    end

    always_comb begin
        prox_estado = INICIAL;
        case (estado)
            INICIAL:     prox_estado = iniciar ? PREPARACAO : INICIAL;
            PREPARACAO:  prox_estado = ESPERA;
            ESPERA: begin
                if (jogada_feita)   prox_estado = REGISTRA;
                else if (timer_fim) prox_estado = FIM_TIMEOUT;
                else                prox_estado = ESPERA;
            end
            REGISTRA:    prox_estado = COMPARACAO;
            COMPARACAO: begin
                if (!igual)    prox_estado = FIM_ERRO;
                else if (fimC) prox_estado = FIM_ACERTO;
                else           prox_estado = PROXIMO;
            end
            PROXIMO:     prox_estado = ESPERA;
            FIM_ACERTO:  prox_estado = iniciar ? PREPARACAO : FIM_ACERTO;
            FIM_ERRO:    prox_estado = iniciar ? PREPARACAO : FIM_ERRO;
            FIM_TIMEOUT: prox_estado = iniciar ? PREPARACAO : FIM_TIMEOUT;
            default:     prox_estado = INICIAL;
        endcase
    end

    always_comb begin
        zeraC     = 1'b0;
        contaC    = 1'b0;
        zeraR     = 1'b0;
        registraR = 1'b0;
        pronto    = 1'b0;
        acertou   = 1'b0;
        errou     = 1'b0;
        timeout   = 1'b0;
        case (estado)
            PREPARACAO: begin
                zeraC = 1'b1;
                zeraR = 1'b1;
            end
            REGISTRA:   registraR = 1'b1;
            PROXIMO:    contaC = 1'b1;
            FIM_ACERTO: begin
                pronto  = 1'b1;
                acertou = 1'b1;
            end
            FIM_ERRO: begin
                pronto = 1'b1;
                errou  = 1'b1;
            end
            FIM_TIMEOUT: begin
                pronto  = 1'b1;
                errou   = 1'b1;
                timeout = 1'b1;
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_unidade_controle_jogo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_unidade_controle_jogo: directed self-checking bench for the game FSM. |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_unidade_controle_jogo;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       iniciar = 1'b0;
    logic       jogada_feita = 1'b0;
    logic       igual = 1'b0;
    logic       fimC = 1'b0;
    logic       zeraC, contaC, zeraR, registraR;
    logic       pronto, acertou, errou, timeout;
    logic [3:0] db_estado;

    int total = 0;
    int bad   = 0;
    int n_conta = 0;
    int n_zera  = 0;

    // Observed word: {db_estado, zeraC, contaC, zeraR, registraR, pronto, acertou, errou, timeout}
    localparam logic [11:0] S_INI  = 12'h000;
    localparam logic [11:0] S_PREP = 12'h1A0;
    localparam logic [11:0] S_ESP  = 12'h200;
    localparam logic [11:0] S_REG  = 12'h410;
    localparam logic [11:0] S_CMP  = 12'h500;
    localparam logic [11:0] S_PROX = 12'h640;
    localparam logic [11:0] S_OK   = 12'hA0C;
    localparam logic [11:0] S_ERR  = 12'hE0A;
    localparam logic [11:0] S_TO   = 12'hD0B;

    unidade_controle_jogo #(.TIMEOUT(8), .TW(4)) dut (
        .clock(clock), .reset(reset), .iniciar(iniciar),
        .jogada_feita(jogada_feita), .igual(igual), .fimC(fimC),
        .zeraC(zeraC), .contaC(contaC), .zeraR(zeraR), .registraR(registraR),
        .pronto(pronto), .acertou(acertou), .errou(errou), .timeout(timeout),
        .db_estado(db_estado)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (contaC) n_conta <= n_conta + 1;
        if (zeraC)  n_zera  <= n_zera + 1;
    end

    function automatic logic [11:0] obs();
        return {db_estado, zeraC, contaC, zeraR, registraR, pronto, acertou, errou, timeout};
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Entered in the first espera cycle; leaves in the next espera cycle or a fim state.
    task automatic play(input logic ok, input logic last);
        tick();
        check_eq("espera_c2", obs(), S_ESP);
        jogada_feita = 1'b1;
        igual = ok;
        fimC = last;
        tick();
        check_eq("registra", obs(), S_REG);
        jogada_feita = 1'b0;
        tick();
        check_eq("comparacao", obs(), S_CMP);
        tick();
        if (!ok)       check_eq("fim_erro", obs(), S_ERR);
        else if (last) check_eq("fim_acerto", obs(), S_OK);
        else begin
            check_eq("proximo", obs(), S_PROX);
            tick();
            check_eq("espera_c1", obs(), S_ESP);
        end
        igual = 1'b0;
        fimC = 1'b0;
    endtask

    task automatic start();
        iniciar = 1'b1;
        tick();
        check_eq("preparacao", obs(), S_PREP);
        iniciar = 1'b0;
        tick();
        check_eq("espera_entry", obs(), S_ESP);
    endtask

    initial begin
        int c0;
        int z0;
        reset = 1'b0;
        tick();
        check_eq("reset_state", obs(), S_INI);
        reset = 1'b1;
        tick();
        check_eq("idle_hold", obs(), S_INI);

        // Perfect round
        c0 = n_conta;
        z0 = n_zera;
        start();
        for (int i = 0; i < 16; i++) play(1'b1, i == 15);
        check_eq("perfect_contaC", n_conta - c0, 15);
        check_eq("perfect_zeraC", n_zera - z0, 1);
        tick();
        tick();
        check_eq("acerto_hold", obs(), S_OK);
        jogada_feita = 1'b1;
        tick();
        jogada_feita = 1'b0;
        check_eq("acerto_ign_play", obs(), S_OK);

        // Mismatch on third play
        c0 = n_conta;
        start();
        play(1'b1, 1'b0);
        play(1'b1, 1'b0);
        play(1'b0, 1'b0);
        check_eq("erro_contaC", n_conta - c0, 2);
        tick();
        check_eq("erro_hold", obs(), S_ERR);

        // Restart with a stray play during preparacao, then full timeout
        iniciar = 1'b1;
        tick();
        check_eq("restart_prep", obs(), S_PREP);
        iniciar = 1'b0;
        jogada_feita = 1'b1;
        tick();
        jogada_feita = 1'b0;
        check_eq("restart_espera", obs(), S_ESP);
        for (int i = 0; i < 7; i++) tick();
        check_eq("espera_c8", obs(), S_ESP);
        tick();
        check_eq("fim_timeout", obs(), S_TO);
        iniciar = 1'b1;
        tick();
        check_eq("iniciar_in_prep", obs(), S_PREP);
        tick();
        iniciar = 1'b0;
        check_eq("iniciar_ignored", obs(), S_ESP);

        // Race: play on the 8th espera cycle beats the timeout
        for (int i = 0; i < 7; i++) tick();
        check_eq("race_c8", obs(), S_ESP);
        jogada_feita = 1'b1;
        igual = 1'b1;
        tick();
        jogada_feita = 1'b0;
        check_eq("race_registra", obs(), S_REG);
        tick();
        tick();
        check_eq("race_proximo", obs(), S_PROX);
        tick();
        igual = 1'b0;
        check_eq("race_espera", obs(), S_ESP);

        // Reset mid-round at address 5, timer partly advanced
        iniciar = 1'b1;
        reset = 1'b0;
        tick();
        reset = 1'b1;
        iniciar = 1'b0;
        check_eq("reset_pre", obs(), S_INI);
        start();
        for (int i = 0; i < 5; i++) play(1'b1, 1'b0);
        for (int i = 0; i < 4; i++) tick();
        reset = 1'b0;
        jogada_feita = 1'b1;
        tick();
        reset = 1'b1;
        jogada_feita = 1'b0;
        check_eq("reset_mid", obs(), S_INI);
        tick();
        check_eq("reset_stay", obs(), S_INI);
        start();
        for (int i = 0; i < 7; i++) tick();
        check_eq("timer_cleared", obs(), S_ESP);
        tick();
        check_eq("timeout_again", obs(), S_TO);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/unidade_controle_jogo.md
Name: unidade_controle_jogo

Overview:
Moore FSM that sequences the memory-game datapath. The datapath contains the 4-bit address counter, the 16x4 sync ROM, the 4-bit play register, the comparator and the play edge detector. The block clears the datapath, waits for each play, latches it, checks it against the ROM word and advances the address. It ends the round on a full match, a mismatch or a per-play timeout, and sits beside the datapath in the top-level circuit.

Parameters:
TIMEOUT, 5000, clock cycles allowed in the wait state before the play is declared timed out (minimum 2)
TW, 13, width of the internal timeout counter; must satisfy 2**TW > TIMEOUT

Ports:
clock  input  1  system clock, rising edge
reset  input  1  synchronous, active-low reset
iniciar  input  1  start/restart request, level-sampled
jogada_feita  input  1  one-cycle pulse from the datapath edge detector
igual  input  1  comparator equal output (ROM word == registered play)
fimC  input  1  counter rco, high when address = 15
zeraC  output  1  clear address counter (active-high; datapath inverts)
contaC  output  1  count enable for address counter
zeraR  output  1  clear play register
registraR  output  1  load enable for play register
pronto  output  1  round finished
acertou  output  1  round finished, all 16 plays correct
errou  output  1  round finished by mismatch or timeout
timeout  output  1  round finished by timeout
db_estado  output  4  current state code, debug

Behaviour:
- Reset: reset=0 at a rising edge -> state inicial, timeout counter = 0. Reset has priority over every other input in every state, including mid-round.
- Reset output values: all outputs 0, db_estado=0000.
- All outputs are decoded from the state only (Moore). No input reaches an output combinationally.
- States (db_estado), outputs high, transitions:
  - inicial (0000): no outputs high. iniciar=1 -> preparacao, else stay.
  - preparacao (0001): zeraC, zeraR high. Always -> espera.
  - espera (0010): no outputs high. Timer increments each cycle here.
    - jogada_feita=1 -> registra.
    - else timer == TIMEOUT-1 -> fim_timeout.
    - else stay.
  - registra (0100): registraR high. Always -> comparacao.
  - comparacao (0101): no outputs high.
    - igual=0 -> fim_erro.
    - igual=1 and fimC=1 -> fim_acerto.
    - igual=1 and fimC=0 -> proximo.
  - proximo (0110): contaC high. Always -> espera.
  - fim_acerto (1010): pronto, acertou high.
  - fim_erro (1110): pronto, errou high.
  - fim_timeout (1101): pronto, errou, timeout high.
  - In the three fim_* states: iniciar=1 -> preparacao, else hold.
- Timeout counter:
  - Cleared to 0 in every state other than espera.
  - Counts 0..TIMEOUT-1 during espera, so timeout fires on the TIMEOUT-th consecutive espera cycle.
  - No wrap: it never passes TIMEOUT-1.
- Simultaneous events:
  - jogada_feita on the same cycle as timer == TIMEOUT-1 -> the play wins (registra).
  - iniciar asserted outside inicial/fim_* states is ignored.
  - jogada_feita outside espera is ignored and not queued.
- ROM timing: the ROM is synchronous. The address changes at the end of proximo and the ROM output is valid from the second espera cycle onward. Because espera is never left before its first cycle ends, igual is valid in comparacao.
- Latency: one play takes 3 cycles from the jogada_feita pulse to the next espera (registra, comparacao, proximo). A perfect round of 16 plays ends in fim_acerto 2 cycles after the 16th pulse.
- Unused state codes -> inicial on the next edge, all outputs 0.

Test Plan:
- Reset mid-round: drive reset=0 for 1 edge while in espera at address 5 -> state 0000, all outputs 0, timer 0. With iniciar=0 it stays in inicial.
- Perfect round (TIMEOUT=8): iniciar pulse, then 16 plays matching ROM words 0..15, each pulse ≥2 cycles into espera.
  - zeraC and zeraR high for 1 cycle.
  - contaC pulses 15 times.
  - db_estado ends at 1010 with pronto=1, acertou=1, errou=0.
  - The state holds until iniciar.
- Mismatch on 3rd play: plays 0 and 1 correct, play 2 wrong -> 1110 with pronto=1, errou=1, acertou=0, timeout=0. contaC pulsed exactly 2 times.
- Timeout (TIMEOUT=8): after preparacao, hold jogada_feita=0 -> espera for exactly 8 cycles, then 1101 with pronto=1, errou=1, timeout=1.
- Race (TIMEOUT=8): jogada_feita pulses on the 8th espera cycle -> registra, not fim_timeout.
- Restart from fim_erro: iniciar=1 -> preparacao next cycle (zeraC=1, zeraR=1), then espera with the timer at 0. A stray jogada_feita during preparacao is ignored.
